// File: rtl/lvl_state_tbl.sv
// Level-state table for the Sat Engine: one {has_bkt, dcd_bin} entry per decision
// level, with decide/backtrack/load writes and a sequential find-backtrack-level search.
module lvl_state_tbl #(
  parameter int NUM_LVLS  = 16,
  parameter int WIDTH_BIN = 10,
  parameter int WIDTH_LVL = 16,
  localparam int WIDTH_LVL_STATES = WIDTH_BIN + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   decide_i,
  input  logic [WIDTH_LVL-1:0]                   decide_lvl_i,
  input  logic [WIDTH_BIN-1:0]                   cur_bin_num_i,
  input  logic                                   find_start_i,
  input  logic [WIDTH_LVL-1:0]                   max_lvl_i,
  output logic                                   find_busy_o,
  output logic                                   find_done_o,
  output logic                                   find_ok_o,
  output logic [WIDTH_LVL-1:0]                   bkt_lvl_o,
  output logic [WIDTH_BIN-1:0]                   bkt_bin_o,
  input  logic                                   apply_bkt_i,
  input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i,
  input  logic                                   wr_states,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o
);

  localparam int IDX_W = $clog2(NUM_LVLS);
  localparam logic [WIDTH_LVL-1:0] LAST_LVL = WIDTH_LVL'(NUM_LVLS - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_LVLS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0] tbl;
  logic [1:0]       state;
  logic [IDX_W-1:0] cursor;
  logic             found;
  logic             bkt_in_range;
  logic             dcd_in_range;

  assign bkt_in_range = (bkt_lvl_i <= LAST_LVL);
  assign dcd_in_range = (decide_lvl_i <= LAST_LVL);

  assign lvl_states_o = tbl;
  assign find_busy_o  = (state != S_IDLE);
  assign find_done_o  = (state == S_DONE);
  assign find_ok_o    = (state == S_DONE) && found;

  // Load beats backtrack beats decide; the losing request is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl <= '0;
    end else if (wr_states) begin
      tbl <= lvl_states_i;
    end else if (apply_bkt_i && bkt_in_range) begin
      for (int k = 0; k < NUM_LVLS; k++) begin
        if (WIDTH_LVL'(k) == bkt_lvl_i) begin
          tbl[k][WIDTH_BIN] <= 1'b1;
        end else if (WIDTH_LVL'(k) > bkt_lvl_i) begin
          tbl[k] <= '0;
        end
      end
    end else if (decide_i && dcd_in_range) begin
      for (int k = 0; k < NUM_LVLS; k++) begin
        if (WIDTH_LVL'(k) == decide_lvl_i) begin
          tbl[k] <= {1'b0, cur_bin_num_i};
        end
      end
    end
  end

  // The scan reads the live table, so a table rewrite mid-scan would make the
  // result meaningless; load and backtrack therefore abort it silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cursor    <= '0;
      found     <= 1'b0;
      bkt_lvl_o <= '0;
      bkt_bin_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (find_start_i) begin
            cursor <= (max_lvl_i > LAST_LVL) ? LAST_IDX : max_lvl_i[IDX_W-1:0];
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (wr_states || apply_bkt_i) begin
            state <= S_IDLE;
          end else if (!tbl[cursor][WIDTH_BIN]) begin
            bkt_lvl_o <= WIDTH_LVL'(cursor);
            bkt_bin_o <= tbl[cursor][WIDTH_BIN-1:0];
            found     <= 1'b1;
            state     <= S_DONE;
          end else if (cursor == '0) begin
            bkt_lvl_o <= '0;
            bkt_bin_o <= '0;
            found     <= 1'b0;
            state     <= S_DONE;
          end else begin
            cursor <= cursor - IDX_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvl_state_tbl.sv
// Scoreboard bench for lvl_state_tbl: a bench-side table model predicts every
// find result and table image; find results are queued at start and popped at done.
module tb_lvl_state_tbl;

  localparam int L  = 16;
  localparam int B  = 10;
  localparam int W  = 16;
  localparam int S  = B + 1;
  localparam int TW = S * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          decide_i;
  logic [W-1:0]  decide_lvl_i;
  logic [B-1:0]  cur_bin_num_i;
  logic          find_start_i;
  logic [W-1:0]  max_lvl_i;
  logic          find_busy_o;
  logic          find_done_o;
  logic          find_ok_o;
  logic [W-1:0]  bkt_lvl_o;
  logic [B-1:0]  bkt_bin_o;
  logic          apply_bkt_i;
  logic [W-1:0]  bkt_lvl_i;
  logic          wr_states;
  logic [TW-1:0] lvl_states_i;
  logic [TW-1:0] lvl_states_o;

  always #5 clk = ~clk;

  lvl_state_tbl #(.NUM_LVLS(L), .WIDTH_BIN(B), .WIDTH_LVL(W)) dut (
    .clk(clk), .rst(rst),
    .decide_i(decide_i), .decide_lvl_i(decide_lvl_i), .cur_bin_num_i(cur_bin_num_i),
    .find_start_i(find_start_i), .max_lvl_i(max_lvl_i),
    .find_busy_o(find_busy_o), .find_done_o(find_done_o), .find_ok_o(find_ok_o),
    .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
    .apply_bkt_i(apply_bkt_i), .bkt_lvl_i(bkt_lvl_i),
    .wr_states(wr_states), .lvl_states_i(lvl_states_i), .lvl_states_o(lvl_states_o)
  );

  typedef struct packed {
    logic         ok;
    logic [W-1:0] lvl;
    logic [B-1:0] bin;
    int           lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [S-1:0] m [L];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [TW-1:0] pack_model();
    logic [TW-1:0] p;
    p = '0;
    for (int k = 0; k < L; k++) p[k*S +: S] = m[k];
    return p;
  endfunction

  function automatic exp_t model_find(input int max);
    exp_t e;
    int   cur;
    logic hit;
    cur = (max > L - 1) ? L - 1 : max;
    e.ok = 1'b0; e.lvl = '0; e.bin = '0; e.lat = 2 + cur;
    hit = 1'b0;
    for (int k = cur; k >= 0; k--) begin
      if (!hit && !m[k][B]) begin
        hit = 1'b1;
        e.ok = 1'b1; e.lvl = W'(k); e.bin = m[k][B-1:0]; e.lat = 2 + cur - k;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tbl(input logic [TW-1:0] v);
    wr_states = 1'b1; lvl_states_i = v;
    step();
    wr_states = 1'b0;
    for (int k = 0; k < L; k++) m[k] = v[k*S +: S];
  endtask

  task automatic decide(input logic [W-1:0] lvl, input logic [B-1:0] bin);
    decide_i = 1'b1; decide_lvl_i = lvl; cur_bin_num_i = bin;
    step();
    decide_i = 1'b0;
    if (int'(lvl) < L) m[lvl] = {1'b0, bin};
  endtask

  task automatic model_apply(input logic [W-1:0] lvl);
    if (int'(lvl) < L) begin
      m[lvl][B] = 1'b1;
      for (int k = 0; k < L; k++) if (k > int'(lvl)) m[k] = '0;
    end
  endtask

  task automatic apply(input logic [W-1:0] lvl);
    apply_bkt_i = 1'b1; bkt_lvl_i = lvl;
    step();
    apply_bkt_i = 1'b0;
    model_apply(lvl);
  endtask

  task automatic start_find(input logic [W-1:0] max);
    find_start_i = 1'b1; max_lvl_i = max;
    step();
    find_start_i = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int budget, output int cnt, output logic to);
    cnt = start_cnt;
    while (find_done_o !== 1'b1 && cnt < budget) begin
      step();
      cnt++;
    end
    to = (find_done_o !== 1'b1);
  endtask

  task automatic test_reset();
    logic [TW-1:0] v;
    rst = 1'b1; wr_states = 1'b1; lvl_states_i = '1; find_start_i = 1'b1; max_lvl_i = 16'd5;
    step(); step();
    n_checks++;
    if ({find_busy_o, find_done_o, find_ok_o} !== 3'b000 || bkt_lvl_o !== '0 || bkt_bin_o !== '0)
      $display("[TB] FAIL rst_outputs: got busy=%b done=%b ok=%b lvl=%h bin=%h want all 0",
               find_busy_o, find_done_o, find_ok_o, bkt_lvl_o, bkt_bin_o);
    else n_pass++;
    n_checks++;
    if (lvl_states_o !== '0) $display("[TB] FAIL rst_table: got %h want 0", lvl_states_o);
    else n_pass++;
    wr_states = 1'b0; find_start_i = 1'b0;
    rst = 1'b0;
    step();
    for (int k = 0; k < L; k++) m[k] = '0;
    n_checks++;
    if (find_busy_o !== 1'b0) $display("[TB] FAIL rst_no_start: got busy=%b want 0", find_busy_o);
    else n_pass++;
    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b0, B'(k + 1)};
    load_tbl(v);
    n_checks++;
    if (lvl_states_o !== v) $display("[TB] FAIL load_view: got %h want %h", lvl_states_o, v);
    else n_pass++;
  endtask

  task automatic test_find_skip();
    logic [TW-1:0] v;
    exp_t e;
    int cnt;
    logic to;
    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b0, B'(k + 1)};
    v[5*S +: S] = {1'b1, 10'd6};
    v[4*S +: S] = {1'b1, 10'd5};
    v[3*S +: S] = {1'b0, 10'h2A};
    load_tbl(v);
    sb_q.push_back(model_find(5));
    start_find(16'd5);
    n_checks++;
    if (find_busy_o !== 1'b1) $display("[TB] FAIL find_busy: got %b want 1", find_busy_o);
    else n_pass++;
    wait_done(1, 30, cnt, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || find_ok_o !== e.ok || bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin || cnt != e.lat)
      $display("[TB] FAIL find_skip: got ok=%b lvl=%0d bin=%h lat=%0d to=%b want ok=%b lvl=%0d bin=%h lat=%0d",
               find_ok_o, bkt_lvl_o, bkt_bin_o, cnt, to, e.ok, e.lvl, e.bin, e.lat);
    else n_pass++;
    step();
    n_checks++;
    if (find_done_o !== 1'b0 || find_ok_o !== 1'b0 || find_busy_o !== 1'b0)
      $display("[TB] FAIL done_one_cycle: got done=%b ok=%b busy=%b want 0 0 0", find_done_o, find_ok_o, find_busy_o);
    else n_pass++;
    n_checks++;
    if (bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin)
      $display("[TB] FAIL result_hold: got lvl=%0d bin=%h want lvl=%0d bin=%h", bkt_lvl_o, bkt_bin_o, e.lvl, e.bin);
    else n_pass++;
  endtask

  task automatic test_clamp_no_hit();
    logic [TW-1:0] v;
    exp_t e;
    int cnt;
    logic to;
    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b1, B'(k + 7)};
    load_tbl(v);
    sb_q.push_back(model_find(100));
    start_find(16'd100);
    wait_done(1, 40, cnt, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || find_ok_o !== e.ok || bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin || cnt != e.lat)
      $display("[TB] FAIL clamp_no_hit: got ok=%b lvl=%0d bin=%h lat=%0d to=%b want ok=%b lvl=%0d bin=%h lat=%0d",
               find_ok_o, bkt_lvl_o, bkt_bin_o, cnt, to, e.ok, e.lvl, e.bin, e.lat);
    else n_pass++;
    step();
  endtask

  task automatic test_apply();
    load_tbl('0);
    for (int k = 0; k < 8; k++) decide(W'(k), B'(10'h100 + k));
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL decide_fill: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
    apply(16'd4);
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL apply_table: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
    n_checks++;
    if (lvl_states_o[4*S +: S] !== {1'b1, 10'h104} || lvl_states_o[TW-1:5*S] !== '0)
      $display("[TB] FAIL apply_entry4: got e4=%h upper=%h want e4=504 upper=0",
               lvl_states_o[4*S +: S], lvl_states_o[TW-1:5*S]);
    else n_pass++;
  endtask

  task automatic test_priority();
    logic [TW-1:0] v;
    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b0, B'(3 * k + 1)};
    wr_states = 1'b1; lvl_states_i = v;
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd0;
    decide_i = 1'b1; decide_lvl_i = 16'd0; cur_bin_num_i = 10'h3FF;
    step();
    wr_states = 1'b0; apply_bkt_i = 1'b0; decide_i = 1'b0;
    for (int k = 0; k < L; k++) m[k] = v[k*S +: S];
    n_checks++;
    if (lvl_states_o !== v) $display("[TB] FAIL prio_load: got %h want %h", lvl_states_o, v);
    else n_pass++;
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd2;
    decide_i = 1'b1; decide_lvl_i = 16'd1; cur_bin_num_i = 10'h3FF;
    step();
    apply_bkt_i = 1'b0; decide_i = 1'b0;
    model_apply(16'd2);
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL prio_apply: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
    decide(16'd16, 10'h155);
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL decide_oor: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
    apply(16'd16);
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL apply_oor: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
    decide(16'd15, 10'h2AA);
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL decide_top: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [TW-1:0] v;
    exp_t e;
    int cnt;
    int done_seen;
    logic to;
    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b1, B'(k)};
    v[2*S +: S] = {1'b0, 10'h055};
    load_tbl(v);
    sb_q.push_back(model_find(15));
    start_find(16'd15);
    wait_done(1, 40, cnt, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || find_ok_o !== e.ok || bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin || cnt != e.lat)
      $display("[TB] FAIL find_long: got ok=%b lvl=%0d bin=%h lat=%0d to=%b want ok=%b lvl=%0d bin=%h lat=%0d",
               find_ok_o, bkt_lvl_o, bkt_bin_o, cnt, to, e.ok, e.lvl, e.bin, e.lat);
    else n_pass++;
    step();
    start_find(16'd15);
    step();
    apply(16'd10);
    n_checks++;
    if (find_busy_o !== 1'b0 || find_done_o !== 1'b0)
      $display("[TB] FAIL abort_idle: got busy=%b done=%b want 0 0", find_busy_o, find_done_o);
    else n_pass++;
    n_checks++;
    if (lvl_states_o !== pack_model()) $display("[TB] FAIL abort_table: got %h want %h", lvl_states_o, pack_model());
    else n_pass++;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (find_done_o === 1'b1) done_seen++;
      step();
    end
    n_checks++;
    if (done_seen != 0) $display("[TB] FAIL abort_no_done: got %0d done pulses want 0", done_seen);
    else n_pass++;
    n_checks++;
    if (bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin)
      $display("[TB] FAIL abort_hold: got lvl=%0d bin=%h want lvl=%0d bin=%h", bkt_lvl_o, bkt_bin_o, e.lvl, e.bin);
    else n_pass++;

    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b1, B'(k)};
    load_tbl(v);
    start_find(16'd15);
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (find_busy_o !== 1'b0 || lvl_states_o !== '0 || bkt_lvl_o !== '0 || bkt_bin_o !== '0)
      $display("[TB] FAIL rst_midscan: got busy=%b tbl=%h lvl=%0d bin=%h want all 0",
               find_busy_o, lvl_states_o, bkt_lvl_o, bkt_bin_o);
    else n_pass++;
    step();
    rst = 1'b0;
    for (int k = 0; k < L; k++) m[k] = '0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (find_done_o === 1'b1) done_seen++;
      step();
    end
    n_checks++;
    if (done_seen != 0) $display("[TB] FAIL rst_no_done: got %0d done pulses want 0", done_seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] v;
    exp_t e;
    int cnt;
    logic to;
    for (int k = 0; k < L; k++) v[k*S +: S] = {1'b1, B'(k)};
    load_tbl(v);
    start_find(16'd15);
    decide_i = 1'b1; decide_lvl_i = 16'd14; cur_bin_num_i = 10'h1AB;
    m[14] = {1'b0, 10'h1AB};
    sb_q.push_back(model_find(15));
    step();
    decide_i = 1'b0;
    wait_done(2, 30, cnt, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || find_ok_o !== e.ok || bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin || cnt != e.lat)
      $display("[TB] FAIL decide_in_scan: got ok=%b lvl=%0d bin=%h lat=%0d to=%b want ok=%b lvl=%0d bin=%h lat=%0d",
               find_ok_o, bkt_lvl_o, bkt_bin_o, cnt, to, e.ok, e.lvl, e.bin, e.lat);
    else n_pass++;
    find_start_i = 1'b1; max_lvl_i = 16'd3;
    step();
    find_start_i = 1'b0;
    n_checks++;
    if (find_busy_o !== 1'b0 || find_done_o !== 1'b0 || find_ok_o !== 1'b0)
      $display("[TB] FAIL start_in_done: got busy=%b done=%b ok=%b want 0 0 0", find_busy_o, find_done_o, find_ok_o);
    else n_pass++;
    sb_q.push_back(model_find(14));
    start_find(16'd14);
    wait_done(1, 30, cnt, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || find_ok_o !== e.ok || bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin || cnt != e.lat)
      $display("[TB] FAIL back_to_back: got ok=%b lvl=%0d bin=%h lat=%0d to=%b want ok=%b lvl=%0d bin=%h lat=%0d",
               find_ok_o, bkt_lvl_o, bkt_bin_o, cnt, to, e.ok, e.lvl, e.bin, e.lat);
    else n_pass++;
    step();
    sb_q.push_back(model_find(0));
    start_find(16'd0);
    wait_done(1, 30, cnt, to);
    e = sb_q.pop_front();
    n_checks++;
    if (to || find_ok_o !== e.ok || bkt_lvl_o !== e.lvl || bkt_bin_o !== e.bin || cnt != e.lat)
      $display("[TB] FAIL find_lvl0: got ok=%b lvl=%0d bin=%h lat=%0d to=%b want ok=%b lvl=%0d bin=%h lat=%0d",
               find_ok_o, bkt_lvl_o, bkt_bin_o, cnt, to, e.ok, e.lvl, e.bin, e.lat);
    else n_pass++;
    step();
  endtask

  initial begin
    rst = 1'b1;
    decide_i = 1'b0; decide_lvl_i = '0; cur_bin_num_i = '0;
    find_start_i = 1'b0; max_lvl_i = '0;
    apply_bkt_i = 1'b0; bkt_lvl_i = '0;
    wr_states = 1'b0; lvl_states_i = '0;
    test_reset();
    test_find_skip();
    test_clamp_no_hit();
    test_apply();
    test_priority();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
